// File: rtl/rv_pkg.sv
// -----------------------------------------------------------------------------
// rv_pkg
// Definitions shared by the fetch stage and the main decode controller:
//   - fetchState_e  : fetch FSM state encoding
//   - BUBBLE_INSTR  : word presented downstream when no instruction is held
//   - PC_INCR       : sequential PC step
//   - OP_*          : major opcode field values decoded by the controller
// -----------------------------------------------------------------------------
package rv_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,  // presenting a fetch request
        S_WAIT = 2'd1,  // request accepted, waiting for read data
        S_OUT  = 2'd2,  // IF/ID register holds an instruction for decode
        S_DROP = 2'd3   // waiting for a response that a redirect made stale
    } fetchState_e;

    // Opcode 0 is the controller's default decode: every control deasserted.
    localparam logic [31:0] BUBBLE_INSTR = 32'h0000_0000;

    localparam int PC_INCR = 4;

    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

endpackage : rv_pkg

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage
// Instruction-fetch stage feeding the main decode controller. Holds the PC,
// issues one instruction-memory read at a time, captures the response into
// the IF/ID register and offers it downstream over valid/ready. A redirect
// from branch/jump resolution overrides every other event in its cycle.
//
// Ports
//   clk, rst_n        clock (rising edge), async active-low reset
//   imem_req_valid    fetch request valid (held until accepted)
//   imem_req_ready    memory accepts the request
//   imem_req_addr     fetch address, always equal to the PC
//   imem_rsp_valid    read data valid, one per accepted request
//   imem_rsp_data     instruction word
//   redirect_valid    load a new PC this cycle
//   redirect_pc       redirect target (low two bits ignored)
//   id_valid          IF/ID register holds a valid instruction
//   id_ready          decode consumes the held instruction
//   id_pc             PC of the held instruction
//   id_instr          held instruction, BUBBLE when id_valid=0
//   id_opcode         id_instr[6:0], drives the controller opcode input
// -----------------------------------------------------------------------------
module if_stage
    import rv_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [31:0]     BUBBLE   = BUBBLE_INSTR
) (
    input  logic            clk,
    input  logic            rst_n,

    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,

    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,

    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [31:0]     id_instr,
    output logic [6:0]      id_opcode
);

    fetchState_e     state;
    fetchState_e     nextState;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] idPc;
    logic [31:0]     idInstr;

    logic            reqFire;      // request handshake this cycle
    logic            rspCapture;   // response lands in the IF/ID register
    logic            outstanding;  // a read is in flight after this cycle
    logic [XLEN-1:0] redirectAligned;

    assign reqFire         = (state == S_REQ) && imem_req_ready;
    assign rspCapture      = (state == S_WAIT) && imem_rsp_valid && !redirect_valid;
    assign redirectAligned = {redirect_pc[XLEN-1:2], 2'b00};

    // A redirect must not let a still-pending response be mistaken for the
    // instruction at the new target, so we park in S_DROP until it returns.
    assign outstanding = ((state == S_WAIT) && !imem_rsp_valid) ||
                         reqFire ||
                         ((state == S_DROP) && !imem_rsp_valid);

    // ---------------------------------------------------------------- state
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_REQ;
        end else begin
            state <= nextState;
        end
    end

    // ----------------------------------------------------------- next state
    // NOTE: the default assignment at the top keeps this block free of
    // inferred latches on paths no case arm covers.
    always_comb begin
        nextState = state;
        if (redirect_valid) begin
            nextState = outstanding ? S_DROP : S_REQ;
        end else begin
            unique case (state)
                S_REQ:   if (imem_req_ready) nextState = S_WAIT;
                S_WAIT:  if (imem_rsp_valid) nextState = S_OUT;
                S_OUT:   if (id_ready)       nextState = S_REQ;
                S_DROP:  if (imem_rsp_valid) nextState = S_REQ;
                default:                     nextState = S_REQ;
            endcase
        end
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        imem_req_valid = (state == S_REQ);
        id_valid       = (state == S_OUT);
    end

    assign imem_req_addr = pc;
    assign id_pc         = idPc;
    assign id_instr      = idInstr;
    assign id_opcode     = idInstr[6:0];

    // ------------------------------------------------------------- datapath
    // The PC advances only when a fetch completes, so it always names the
    // next instruction to request; redirects overwrite it unconditionally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= RESET_PC;
            idPc    <= '0;
            idInstr <= BUBBLE;
        end else if (redirect_valid) begin
            pc      <= redirectAligned;
            idInstr <= BUBBLE;
        end else if (rspCapture) begin
            idInstr <= imem_rsp_data;
            idPc    <= pc;
            pc      <= pc + XLEN'(PC_INCR);
        end else if ((state == S_OUT) && id_ready) begin
            idInstr <= BUBBLE;
        end
    end

endmodule : if_stage
